mem_port_arbiter: RTL

Arbiter and sequencer for the single-ported 1024 x 32 unified instruction/data memory of the MIPS32 pipeline. It shares the memory among three requesters: the host/loader port, the data port (MEM stage LW/SW) and the instruction port (IF fetch). It serialises their transactions into one memory access at a time and returns read data with a per-requester acknowledge. Fixed priority is host > data > instr, with a starvation guard so that instruction fetch cannot be locked out by data traffic.

---
 rtl/mem_port_arbiter_if.sv | 60 ++++++
 rtl/mem_port_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the three requester ports (host, data, instruction), the memory-side
// strobes and the status outputs of mem_port_arbiter.
//   slave  : arbiter view (requests and mem_rdata in; acks, rd_data, mem_*,
//            busy and owner out)
//   master : requester/memory-model view (directions mirrored)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  // host / loader port
  logic          h_req;
  logic          h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic          h_ack;
  // data port (MEM stage)
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  // instruction fetch port (read only)
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  // shared read return
  logic [DW-1:0] rd_data;
  // memory side
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  // status
  logic          busy;
  logic [1:0]    owner;

  modport slave (
    input  h_req, h_we, h_addr, h_wdata,
    input  d_req, d_we, d_addr, d_wdata,
    input  i_req, i_addr,
    input  mem_rdata,
    output h_ack, d_ack, i_ack, rd_data,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy, owner
  );

  modport master (
    output h_req, h_we, h_addr, h_wdata,
    output d_req, d_we, d_addr, d_wdata,
    output i_req, i_addr,
    output mem_rdata,
    input  h_ack, d_ack, i_ack, rd_data,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares a single-ported unified instruction/data memory between the host,
// data and instruction requesters. One transaction at a time:
//   IDLE -> ISSUE (mem_en one cycle) -> [WAIT for reads] -> RESP (ack) -> IDLE
// Priority host > data > instr, except that instr is forced once STARVE_MAX
// data grants have been made while instr was waiting (host still wins).
// Ports:
//   clk    : clock, all state on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : mem_port_arbiter_if.slave (requests, acks, rd_data, mem_*,
//            busy, owner)
// All outputs are driven straight from registers.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int READ_LAT   = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_port_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [1:0] OWN_NONE  = 2'b00;
  localparam logic [1:0] OWN_INSTR = 2'b01;
  localparam logic [1:0] OWN_DATA  = 2'b10;
  localparam logic [1:0] OWN_HOST  = 2'b11;

  // WAIT counts down from READ_LAT-1 so mem_rdata is sampled READ_LAT cycles
  // after the mem_en cycle.
  localparam logic [2:0] CNT_LOAD   = 3'(READ_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e        state_q,     state_d;
  logic [1:0]    owner_q,     owner_d;
  logic [2:0]    cnt_q,       cnt_d;
  logic [3:0]    starve_q,    starve_d;
  logic          mem_en_q,    mem_en_d;
  logic          mem_we_q,    mem_we_d;
  logic [AW-1:0] mem_addr_q,  mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] rd_data_q,   rd_data_d;
  logic          h_ack_q,     h_ack_d;
  logic          d_ack_q,     d_ack_d;
  logic          i_ack_q,     i_ack_d;
  logic          busy_q,      busy_d;

  // Next-state logic: arbitration in IDLE, sequencing through ISSUE/WAIT/RESP.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_data_d   = rd_data_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.h_req) begin
          // host grants leave the starvation count untouched
          state_d     = ST_ISSUE;
          owner_d     = OWN_HOST;
          mem_we_d    = bus.h_we;
          mem_addr_d  = bus.h_addr;
          mem_wdata_d = bus.h_wdata;
        end else if (bus.i_req && (starve_q == STARVE_LIM)) begin
          // starvation guard: instr overrides a pending data request
          state_d    = ST_ISSUE;
          owner_d    = OWN_INSTR;
          mem_we_d   = 1'b0;
          mem_addr_d = bus.i_addr;
          starve_d   = 4'd0;
        end else if (bus.d_req) begin
          state_d     = ST_ISSUE;
          owner_d     = OWN_DATA;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          if (bus.i_req && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 4'd1;
          end else begin
            starve_d = starve_q;
          end
        end else if (bus.i_req) begin
          state_d    = ST_ISSUE;
          owner_d    = OWN_INSTR;
          mem_we_d   = 1'b0;
          mem_addr_d = bus.i_addr;
          starve_d   = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        if (mem_we_q) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end

      ST_WAIT: begin
        if (cnt_q == 3'd0) begin
          rd_data_d = bus.mem_rdata;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end

      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // Registered strobes are precomputed from the next state; the ack goes to
  // whoever owns the transaction that is about to enter RESP.
  always_comb begin
    mem_en_d = (state_d == ST_ISSUE);
    busy_d   = (state_d != ST_IDLE);
    h_ack_d  = (state_d == ST_RESP) && (owner_q == OWN_HOST);
    d_ack_d  = (state_d == ST_RESP) && (owner_q == OWN_DATA);
    i_ack_d  = (state_d == ST_RESP) && (owner_q == OWN_INSTR);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_NONE;
      cnt_q       <= 3'd0;
      starve_q    <= 4'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {AW{1'b0}};
      mem_wdata_q <= {DW{1'b0}};
      rd_data_q   <= {DW{1'b0}};
      h_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_ack_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_data_q   <= rd_data_d;
      h_ack_q     <= h_ack_d;
      d_ack_q     <= d_ack_d;
      i_ack_q     <= i_ack_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.h_ack     = h_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.i_ack     = i_ack_q;
  assign bus.busy      = busy_q;
  assign bus.owner     = owner_q;

endmodule
